// File: rtl/scarv_soc_dbg_master_if.sv
`default_nettype none
// ============================================================================
// Module   : scarv_soc_dbg_master_if
// Brief    : Byte-stream (rx/tx) and memory-initiator bundle for the debug
//            bus master.
// Revision : 1.0
// ============================================================================
interface scarv_soc_dbg_master_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready,
        output tx_valid, tx_data,
        input  tx_ready,
        output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready,
        input  tx_valid, tx_data,
        output tx_ready,
        input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/scarv_soc_dbg_master.sv
`default_nettype none
// ============================================================================
// Module   : scarv_soc_dbg_master
// Brief    : Parses W/R command frames from a byte stream and issues single
//            word memory transactions, returning read data and status bytes.
// Revision : 1.0
// ============================================================================
module scarv_soc_dbg_master #(
    parameter logic [7:0] CMD_WRITE = 8'h57,
    parameter logic [7:0] CMD_READ  = 8'h52,
    parameter logic [7:0] ST_OK     = 8'h00,
    parameter logic [7:0] ST_BUSERR = 8'h01,
    parameter logic [7:0] ST_BADCMD = 8'hEE
) (
    input  wire logic              f_clk,
    input  wire logic              g_resetn,
    scarv_soc_dbg_master_if.master bus,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_REQ  = 3'd3,
        S_RSP  = 3'd4,
        S_TXD  = 3'd5,
        S_TXS  = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_is_write;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [23:0] r_rdata;
    logic        r_err;
    logic        r_rx_ready;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_mem_req;
    logic        r_mem_ack;
    logic        r_busy;

    logic        w_rx_fire;
    logic        w_tx_fire;

    assign w_rx_fire = bus.rx_valid & r_rx_ready;
    assign w_tx_fire = r_tx_valid & bus.tx_ready;

    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state    <= S_IDLE;
            r_is_write <= 1'b0;
            r_cnt      <= 2'd0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 24'h0;
            r_err      <= 1'b0;
            r_rx_ready <= 1'b1;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_mem_req  <= 1'b0;
            r_mem_ack  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        r_busy <= 1'b1;
                        if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                            r_is_write <= (bus.rx_data == CMD_WRITE);
                            r_cnt      <= 2'd0;
                            r_state    <= S_ADDR;
                        end else begin
                            r_rx_ready <= 1'b0;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= ST_BADCMD;
                            r_state    <= S_TXS;
                        end
                    end
                end
                // Fields arrive LSB first, so shift each byte in from the top.
                S_ADDR: begin
                    if (w_rx_fire) begin
                        r_addr <= {bus.rx_data, r_addr[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= S_DATA;
                            end else begin
                                r_rx_ready <= 1'b0;
                                r_mem_req  <= 1'b1;
                                r_state    <= S_REQ;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata <= {bus.rx_data, r_wdata[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_rx_ready <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_mem_ack <= 1'b1;
                        r_state   <= S_RSP;
                    end
                end
                // Byte 0 of read data goes straight to tx; only the upper 24 bits are kept.
                S_RSP: begin
                    if (bus.mem_recv) begin
                        r_mem_ack  <= 1'b0;
                        r_err      <= bus.mem_error;
                        r_rdata    <= bus.mem_rdata[31:8];
                        r_tx_valid <= 1'b1;
                        if (r_is_write) begin
                            r_tx_data <= bus.mem_error ? ST_BUSERR : ST_OK;
                            r_state   <= S_TXS;
                        end else begin
                            r_tx_data <= bus.mem_rdata[7:0];
                            r_cnt     <= 2'd0;
                            r_state   <= S_TXD;
                        end
                    end
                end
                S_TXD: begin
                    if (w_tx_fire) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_tx_data <= r_err ? ST_BUSERR : ST_OK;
                            r_state   <= S_TXS;
                        end else begin
                            r_tx_data <= r_rdata[7:0];
                            r_rdata   <= {8'h00, r_rdata[23:8]};
                        end
                    end
                end
                S_TXS: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready  = r_rx_ready;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_data   = r_tx_data;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_wen   = r_is_write;
    assign bus.mem_strb  = 4'hF;
    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_ack   = r_mem_ack;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_scarv_soc_dbg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_scarv_soc_dbg_master
// Brief    : Frame-level bench: acts as byte source, memory target and byte sink.
// Revision : 1.0
// ============================================================================
module tb_scarv_soc_dbg_master;

    logic f_clk    = 1'b0;
    logic g_resetn = 1'b0;
    logic busy;

    always #5 f_clk = ~f_clk;

    scarv_soc_dbg_master_if bus ();

    scarv_soc_dbg_master dut (
        .f_clk    (f_clk),
        .g_resetn (g_resetn),
        .bus      (bus),
        .busy     (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(output bit ok);
        int t;
        ok = 1'b1;
        while (rx_q.size() > 0) begin
            t = 0;
            @(negedge f_clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = rx_q[0];
            while (bus.rx_ready !== 1'b1) begin
                t++;
                if (t > 50) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_timeout: rx_ready=%b required 1", bus.rx_ready);
                    bus.rx_valid = 1'b0;
                    rx_q.delete();
                    ok = 1'b0;
                    return;
                end
                @(negedge f_clk);
            end
            void'(rx_q.pop_front());
            @(posedge f_clk);
            #1;
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic mem_phase(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input int gnt_dly, input int rcv_dly, input bit err,
                             input logic [31:0] rdat);
        int t;
        t = 0;
        @(negedge f_clk);
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_latency: mem_req=%b one cycle after last byte, required 1", bus.mem_req);
        end
        while (bus.mem_req !== 1'b1) begin
            t++;
            if (t > 20) begin
                vectors++;
                miscompares++;
                $display("FAIL req_timeout: mem_req=%b required 1", bus.mem_req);
                return;
            end
            @(negedge f_clk);
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            vectors++;
            if (bus.mem_req !== 1'b1 || bus.mem_ack !== 1'b0 || bus.mem_wen !== wen ||
                bus.mem_addr !== addr || bus.mem_strb !== 4'hF ||
                (wen && bus.mem_wdata !== wdata)) begin
                miscompares++;
                $display("FAIL req_hold cycle %0d: req=%b ack=%b wen=%b addr=%08h wdata=%08h strb=%h, required req=1 ack=0 wen=%b addr=%08h wdata=%08h strb=f",
                         i, bus.mem_req, bus.mem_ack, bus.mem_wen, bus.mem_addr, bus.mem_wdata,
                         bus.mem_strb, wen, addr, wdata);
            end
            if (i < gnt_dly) @(negedge f_clk);
        end
        bus.mem_gnt = 1'b1;
        @(posedge f_clk);
        #1;
        bus.mem_gnt = 1'b0;
        @(negedge f_clk);
        vectors++;
        if (bus.mem_ack !== 1'b1 || bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_ack: ack=%b req=%b after grant, required ack=1 req=0",
                     bus.mem_ack, bus.mem_req);
        end
        repeat (rcv_dly) @(negedge f_clk);
        bus.mem_recv  = 1'b1;
        bus.mem_error = err;
        bus.mem_rdata = rdat;
        @(posedge f_clk);
        #1;
        bus.mem_recv  = 1'b0;
        bus.mem_error = 1'b0;
        bus.mem_rdata = $urandom();
    endtask

    task automatic tx_phase(input int stall_idx, input int stall_len, input int rnd_max);
        int n;
        int hold;
        int t;
        n = exp_tx.size();
        for (int i = 0; i < n; i++) begin
            t = 0;
            if (i == stall_idx) hold = stall_len;
            else if (rnd_max > 0) hold = int'($urandom_range(rnd_max, 0));
            else hold = 0;
            @(negedge f_clk);
            while (bus.tx_valid !== 1'b1) begin
                t++;
                if (t > 40) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_timeout byte %0d: tx_valid=%b required 1", i, bus.tx_valid);
                    exp_tx.delete();
                    return;
                end
                @(negedge f_clk);
            end
            for (int h = 0; h < hold; h++) begin
                vectors++;
                if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_tx[i]) begin
                    miscompares++;
                    $display("FAIL tx_hold byte %0d cycle %0d: valid=%b data=%02h, required valid=1 data=%02h",
                             i, h, bus.tx_valid, bus.tx_data, exp_tx[i]);
                end
                @(negedge f_clk);
            end
            vectors++;
            if (bus.tx_data !== exp_tx[i] || bus.mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL tx_byte %0d: data=%02h mem_req=%b, required data=%02h mem_req=0",
                         i, bus.tx_data, bus.mem_req, exp_tx[i]);
            end
            bus.tx_ready = 1'b1;
            @(posedge f_clk);
            #1;
            bus.tx_ready = 1'b0;
        end
        vectors++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_done: tx_valid=%b rx_ready=%b busy=%b, required 0 1 0",
                     bus.tx_valid, bus.rx_ready, busy);
        end
        exp_tx.delete();
    endtask

    // Reference: frame bytes, bus transaction and reply derived from the frame rules.
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                             input int gnt_dly, input int rcv_dly, input bit err,
                             input logic [31:0] rdat, input int stall_idx, input int stall_len,
                             input int rnd_max);
        bit ok;
        bit is_w;
        bit is_r;
        is_w = (cmd == 8'h57);
        is_r = (cmd == 8'h52);
        rx_q.delete();
        exp_tx.delete();
        rx_q.push_back(cmd);
        if (is_w || is_r)
            for (int i = 0; i < 4; i++) rx_q.push_back(8'((a >> (8 * i)) & 32'hFF));
        if (is_w)
            for (int i = 0; i < 4; i++) rx_q.push_back(8'((d >> (8 * i)) & 32'hFF));
        if (!is_w && !is_r) begin
            exp_tx.push_back(8'hEE);
        end else begin
            if (is_r)
                for (int i = 0; i < 4; i++) exp_tx.push_back(8'((rdat >> (8 * i)) & 32'hFF));
            exp_tx.push_back(err ? 8'h01 : 8'h00);
        end
        send_rx(ok);
        if (!ok) return;
        if (is_w || is_r)
            mem_phase(is_w, a & 32'hFFFF_FFFC, d, gnt_dly, rcv_dly, err, rdat);
        tx_phase(stall_idx, stall_len, rnd_max);
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({bus.rx_ready, bus.tx_valid, bus.tx_data, bus.mem_req, bus.mem_wen, bus.mem_strb,
             bus.mem_addr, bus.mem_wdata, bus.mem_ack, busy} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s: rx_ready=%b tx_valid=%b tx_data=%02h req=%b wen=%b strb=%h addr=%08h wdata=%08h ack=%b busy=%b, required 1 0 00 0 0 f 0 0 0 0",
                     tag, bus.rx_ready, bus.tx_valid, bus.tx_data, bus.mem_req, bus.mem_wen,
                     bus.mem_strb, bus.mem_addr, bus.mem_wdata, bus.mem_ack, busy);
        end
    endtask

    task automatic test_reset;
        g_resetn = 1'b0;
        repeat (3) @(negedge f_clk);
        check_reset_outputs("reset_state");
        g_resetn = 1'b1;
    endtask

    task automatic test_write;
        run_frame(8'h57, 32'h0001_0000, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, -1, 0, 0);
    endtask

    task automatic test_read;
        run_frame(8'h52, 32'h0001_0004, 32'h0, 0, 0, 1'b0, 32'h1234_5678, -1, 0, 0);
    endtask

    task automatic test_buserr_delay;
        run_frame(8'h52, 32'h1000_0003, 32'h0, 5, 2, 1'b1, 32'h0, -1, 0, 0);
    endtask

    task automatic test_badcmd;
        run_frame(8'h41, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0, -1, 0, 0);
        run_frame(8'h52, 32'h0000_0020, 32'h0, 1, 1, 1'b0, 32'hCAFE_F00D, -1, 0, 0);
    endtask

    task automatic test_tx_stall;
        run_frame(8'h52, 32'h0000_0100, 32'h0, 0, 0, 1'b0, 32'hA1B2_C3D4, 1, 10, 0);
    endtask

    task automatic test_reset_in_rsp;
        bit ok;
        int t;
        t = 0;
        rx_q = {8'h52, 8'h10, 8'h20, 8'h30, 8'h40};
        send_rx(ok);
        if (!ok) return;
        @(negedge f_clk);
        while (bus.mem_req !== 1'b1) begin
            t++;
            if (t > 20) begin
                vectors++;
                miscompares++;
                $display("FAIL rst_req_timeout: mem_req=%b required 1", bus.mem_req);
                return;
            end
            @(negedge f_clk);
        end
        bus.mem_gnt = 1'b1;
        @(posedge f_clk);
        #1;
        bus.mem_gnt = 1'b0;
        @(negedge f_clk);
        vectors++;
        if (bus.mem_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_ack: mem_ack=%b required 1", bus.mem_ack);
        end
        #2;
        g_resetn = 1'b0;
        #1;
        check_reset_outputs("reset_in_rsp");
        @(negedge f_clk);
        g_resetn = 1'b1;
        repeat (3) @(negedge f_clk);
        vectors++;
        if (bus.tx_valid !== 1'b0 || bus.mem_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abandon: tx_valid=%b req=%b busy=%b required 0 0 0",
                     bus.tx_valid, bus.mem_req, busy);
        end
        run_frame(8'h57, 32'h2000_0008, 32'h0BAD_F00D, 1, 0, 1'b0, 32'h0, -1, 0, 0);
    endtask

    task automatic test_back_to_back;
        run_frame(8'h57, 32'h0000_0010, 32'h1111_2222, 0, 0, 1'b0, 32'h0, -1, 0, 0);
        run_frame(8'h52, 32'h0000_0010, 32'h0, 0, 0, 1'b0, 32'h3333_4444, -1, 0, 0);
        run_frame(8'h57, 32'h0000_0014, 32'h5555_6666, 0, 0, 1'b1, 32'h0, -1, 0, 0);
    endtask

    task automatic test_random;
        logic [7:0]  cmd;
        int          sel;
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(9, 0));
            if (sel == 0) begin
                cmd = 8'($urandom());
                if (cmd == 8'h57 || cmd == 8'h52) cmd = cmd ^ 8'h80;
            end else if (sel < 5) begin
                cmd = 8'h57;
            end else begin
                cmd = 8'h52;
            end
            run_frame(cmd, $urandom(), $urandom(), int'($urandom_range(4, 0)),
                      int'($urandom_range(4, 0)), ($urandom_range(3, 0) == 0), $urandom(),
                      -1, 0, 2);
        end
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_ready  = 1'b0;
        bus.mem_gnt   = 1'b0;
        bus.mem_recv  = 1'b0;
        bus.mem_error = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_buserr_delay();
        test_badcmd();
        test_tx_stall();
        test_reset_in_rsp();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
